// File: rtl/dfp_addsub_seq.sv
// Digit-serial decimal floating-point add/subtract engine.
// Operands arrive decomposed (sign, biased binary exponent, N BCD digits, inf/nan flags).
// The smaller operand is aligned one digit per cycle. The significands are then added or
// subtracted one digit per cycle, least significant digit first. The result is left
// unnormalised for the downstream normaliser/rounder.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ce                clock enable; freezes all state when low
//   rm, op            rounding mode, 0=add/1=sub (sampled on accept)
//   i_valid/i_ready   operand handshake (i_ready only while idle)
//   a_*/b_*           operand sign, exponent, BCD significand, inf/nan flags
//   o_valid/o_ready   result handshake
//   o_sgn, o_exp      result sign and exponent
//   o_sig             {carry digit, N digits, guard digit}
//   o_sticky          OR of all digits shifted past the guard digit
//   o_inf/o_nan/o_zero result class
module dfp_addsub_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned EW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [2:0]           rm,
  input  logic                 op,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 a_sgn,
  input  logic                 b_sgn,
  input  logic [EW-1:0]        a_exp,
  input  logic [EW-1:0]        b_exp,
  input  logic [N*4-1:0]       a_sig,
  input  logic [N*4-1:0]       b_sig,
  input  logic                 a_inf,
  input  logic                 b_inf,
  input  logic                 a_nan,
  input  logic                 b_nan,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 o_sgn,
  output logic [EW-1:0]        o_exp,
  output logic [(N+2)*4-1:0]   o_sig,
  output logic                 o_sticky,
  output logic                 o_inf,
  output logic                 o_nan,
  output logic                 o_zero
);

  localparam int unsigned WW = (N + 1) * 4;
  localparam int unsigned OW = (N + 2) * 4;
  localparam int unsigned SW = N * 4;
  localparam int unsigned CW = $clog2(N + 2);

  localparam logic [CW-1:0] CntLast = CW'(N);
  localparam logic [CW-1:0] CntMax  = CW'(N + 1);

  // FIN registers the result one cycle before it is presented in DONE.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMP   = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    r_state;

  // Registered operands
  logic [2:0]    r_rm;
  logic          r_op;
  logic          r_a_sgn, r_b_sgn;
  logic [EW-1:0] r_a_exp, r_b_exp;
  logic [SW-1:0] r_a_sig, r_b_sig;
  logic          r_a_inf, r_b_inf, r_a_nan, r_b_nan;

  // Working datapath
  logic [WW-1:0] r_l, r_s, r_res;
  logic          r_carry;
  logic          r_sticky;
  logic          r_sub;
  logic          r_sgn;
  logic [EW-1:0] r_exp;
  logic [CW-1:0] r_cnt;
  logic          r_early;

  // Output registers
  logic          r_o_valid, r_o_sgn, r_o_sticky, r_o_inf, r_o_nan, r_o_zero;
  logic [EW-1:0] r_o_exp;
  logic [OW-1:0] r_o_sig;

  // Compare-stage signals
  logic          w_sbe, w_rsub, w_a_ge;
  logic [SW-1:0] w_l_sig, w_s_sig;
  logic [EW-1:0] w_l_exp, w_s_exp, w_ediff;
  logic          w_l_sgn;
  logic [CW-1:0] w_d;

  logic          w_early, w_e_nan, w_e_inf, w_e_zero, w_e_sgn;
  logic [OW-1:0] w_e_sig;

  // Digit-serial arithmetic signals
  logic [3:0]    w_l_dig, w_s_dig, w_dig;
  logic [4:0]    w_sum, w_sum_adj, w_dif;
  logic          w_c_nxt;
  logic [3:0]    w_cdig;
  logic          w_res_zero;

  assign i_ready  = rst_n & (r_state == S_IDLE);
  assign o_valid  = r_o_valid;
  assign o_sgn    = r_o_sgn;
  assign o_exp    = r_o_exp;
  assign o_sig    = r_o_sig;
  assign o_sticky = r_o_sticky;
  assign o_inf    = r_o_inf;
  assign o_nan    = r_o_nan;
  assign o_zero   = r_o_zero;

  // Operand ordering: larger magnitude by exponent, then significand; ties pick a.
  always_comb begin
    w_sbe   = r_b_sgn ^ r_op;
    w_rsub  = r_a_sgn ^ w_sbe;
    w_a_ge  = (r_a_exp > r_b_exp) || ((r_a_exp == r_b_exp) && (r_a_sig >= r_b_sig));
    w_l_sig = w_a_ge ? r_a_sig : r_b_sig;
    w_s_sig = w_a_ge ? r_b_sig : r_a_sig;
    w_l_exp = w_a_ge ? r_a_exp : r_b_exp;
    w_s_exp = w_a_ge ? r_b_exp : r_a_exp;
    w_l_sgn = w_a_ge ? r_a_sgn : w_sbe;
    w_ediff = w_l_exp - w_s_exp;
    // Beyond N+1 digits every significand digit lands in sticky anyway.
    if (w_ediff > EW'(N + 1)) begin
      w_d = CntMax;
    end else begin
      w_d = w_ediff[CW-1:0];
    end
  end

  // Early-out special cases, highest priority first.
  always_comb begin
    w_early  = 1'b0;
    w_e_nan  = 1'b0;
    w_e_inf  = 1'b0;
    w_e_zero = 1'b0;
    w_e_sgn  = 1'b0;
    w_e_sig  = '0;
    if (r_a_nan) begin
      w_early = 1'b1;
      w_e_nan = 1'b1;
      w_e_sig = {4'h0, r_a_sig, 4'h0};
    end else if (r_b_nan) begin
      w_early = 1'b1;
      w_e_nan = 1'b1;
      w_e_sig = {4'h0, r_b_sig, 4'h0};
    end else if (r_a_inf && r_b_inf && w_rsub) begin
      w_early = 1'b1;
      w_e_nan = 1'b1;
    end else if (r_a_inf || r_b_inf) begin
      w_early = 1'b1;
      w_e_inf = 1'b1;
      w_e_sgn = r_a_inf ? r_a_sgn : w_sbe;
    end else if ((w_rsub && (r_a_exp == r_b_exp) && (r_a_sig == r_b_sig)) ||
                 ((r_a_sig == '0) && (r_b_sig == '0))) begin
      w_early  = 1'b1;
      w_e_zero = 1'b1;
      w_e_sgn  = w_rsub ? (r_rm == 3'd3) : r_a_sgn;
    end
  end

  // One BCD digit of add (carry) or subtract (borrow) per cycle.
  always_comb begin
    w_l_dig   = r_l[3:0];
    w_s_dig   = r_s[3:0];
    w_sum     = {1'b0, w_l_dig} + {1'b0, w_s_dig} + {4'b0000, r_carry};
    w_sum_adj = w_sum - 5'd10;
    w_dif     = {1'b0, w_l_dig} - {1'b0, w_s_dig} - {4'b0000, r_carry};
    if (r_sub) begin
      w_c_nxt = w_dif[4];
      w_dig   = w_dif[4] ? (w_dif[3:0] + 4'd10) : w_dif[3:0];
    end else begin
      w_c_nxt = (w_sum > 5'd9);
      w_dig   = w_c_nxt ? w_sum_adj[3:0] : w_sum[3:0];
    end
    // A subtraction never yields a carry digit; its final borrow is discarded.
    w_cdig     = {3'b000, r_carry & ~r_sub};
    w_res_zero = (r_res == '0) && (w_cdig == 4'h0) && !r_sticky;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rm       <= '0;
      r_op       <= 1'b0;
      r_a_sgn    <= 1'b0;
      r_b_sgn    <= 1'b0;
      r_a_exp    <= '0;
      r_b_exp    <= '0;
      r_a_sig    <= '0;
      r_b_sig    <= '0;
      r_a_inf    <= 1'b0;
      r_b_inf    <= 1'b0;
      r_a_nan    <= 1'b0;
      r_b_nan    <= 1'b0;
      r_l        <= '0;
      r_s        <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_sticky   <= 1'b0;
      r_sub      <= 1'b0;
      r_sgn      <= 1'b0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_early    <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_sgn    <= 1'b0;
      r_o_exp    <= '0;
      r_o_sig    <= '0;
      r_o_sticky <= 1'b0;
      r_o_inf    <= 1'b0;
      r_o_nan    <= 1'b0;
      r_o_zero   <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_rm    <= rm;
            r_op    <= op;
            r_a_sgn <= a_sgn;
            r_b_sgn <= b_sgn;
            r_a_exp <= a_exp;
            r_b_exp <= b_exp;
            r_a_sig <= a_sig;
            r_b_sig <= b_sig;
            r_a_inf <= a_inf;
            r_b_inf <= b_inf;
            r_a_nan <= a_nan;
            r_b_nan <= b_nan;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_early <= w_early;
          if (w_early) begin
            r_o_nan    <= w_e_nan;
            r_o_inf    <= w_e_inf;
            r_o_zero   <= w_e_zero;
            r_o_sgn    <= w_e_sgn;
            r_o_exp    <= '0;
            r_o_sig    <= w_e_sig;
            r_o_sticky <= 1'b0;
            r_state    <= S_FIN;
          end else begin
            r_l      <= {w_l_sig, 4'h0};
            r_s      <= {w_s_sig, 4'h0};
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_sticky <= 1'b0;
            r_sub    <= w_rsub;
            r_sgn    <= w_l_sgn;
            r_exp    <= w_l_exp;
            if (w_d != '0) begin
              r_cnt   <= w_d;
              r_state <= S_ALIGN;
            end else begin
              r_cnt   <= '0;
              r_state <= S_ADD;
            end
          end
        end
        S_ALIGN: begin
          r_s      <= r_s >> 4;
          r_sticky <= r_sticky | (r_s[3:0] != 4'h0);
          if (r_cnt == CW'(1)) begin
            r_cnt   <= '0;
            r_state <= S_ADD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_ADD: begin
          r_l     <= r_l >> 4;
          r_s     <= r_s >> 4;
          r_res   <= {w_dig, r_res[WW-1:4]};
          r_carry <= w_c_nxt;
          if (r_cnt == CntLast) begin
            r_cnt   <= '0;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIN: begin
          if (!r_early) begin
            r_o_nan    <= 1'b0;
            r_o_inf    <= 1'b0;
            r_o_zero   <= w_res_zero;
            r_o_sgn    <= r_sgn;
            r_o_exp    <= w_res_zero ? '0 : r_exp;
            r_o_sig    <= {w_cdig, r_res};
            r_o_sticky <= r_sticky;
          end
          r_o_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (o_ready) begin
            r_o_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfp_addsub_seq.sv
module tb_dfp_addsub_seq;

  localparam int N  = 4;
  localparam int EW = 16;

  logic          clk, rst_n, ce, op, i_valid, i_ready, o_valid, o_ready;
  logic [2:0]    rm;
  logic          a_sgn, b_sgn, a_inf, b_inf, a_nan, b_nan;
  logic [EW-1:0] a_exp, b_exp, o_exp;
  logic [15:0]   a_sig, b_sig;
  logic [23:0]   o_sig;
  logic          o_sgn, o_sticky, o_inf, o_nan, o_zero;

  dfp_addsub_seq #(.N(N), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .rm(rm), .op(op),
    .i_valid(i_valid), .i_ready(i_ready),
    .a_sgn(a_sgn), .b_sgn(b_sgn), .a_exp(a_exp), .b_exp(b_exp),
    .a_sig(a_sig), .b_sig(b_sig), .a_inf(a_inf), .b_inf(b_inf),
    .a_nan(a_nan), .b_nan(b_nan),
    .o_valid(o_valid), .o_ready(o_ready), .o_sgn(o_sgn), .o_exp(o_exp),
    .o_sig(o_sig), .o_sticky(o_sticky), .o_inf(o_inf), .o_nan(o_nan), .o_zero(o_zero)
  );

  typedef struct {
    logic [2:0]  rm;
    logic        op, as, bs, ai, bi, an, bn;
    logic [15:0] ae, be, asig, bsig;
  } stim_t;

  typedef struct {
    logic        nan, inf, zero, sgn, sticky;
    logic [15:0] ex;
    logic [23:0] sig;
    bit          chk_sgn, chk_exp, chk_st;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint pow10(input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2int(input logic [15:0] s);
    longint v = 0;
    for (int i = N - 1; i >= 0; i--) v = v * 10 + longint'(s[i*4+:4]);
    return v;
  endfunction

  function automatic logic [23:0] int2bcd(input longint v);
    logic [23:0] r = '0;
    longint t = v;
    for (int i = 0; i < N + 2; i++) begin
      r[i*4+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: decimal values as integers, guard digit as an extra factor of ten.
  function automatic exp_t model(input stim_t s);
    exp_t   e;
    longint av, bv, lv, sv, sal, p, r;
    int     ae, be, diff, d;
    logic   sbe, rsub, a_l;
    e.nan = 0; e.inf = 0; e.zero = 0; e.sgn = 0; e.sticky = 0; e.ex = '0; e.sig = '0;
    e.chk_sgn = 0; e.chk_exp = 0; e.chk_st = 0; e.lat = 2; e.acc = 0;
    sbe  = s.bs ^ s.op;
    rsub = s.as ^ sbe;
    av   = bcd2int(s.asig);
    bv   = bcd2int(s.bsig);
    ae   = int'(s.ae);
    be   = int'(s.be);
    if (s.an) begin
      e.nan = 1; e.sig = int2bcd(av * 10);
    end else if (s.bn) begin
      e.nan = 1; e.sig = int2bcd(bv * 10);
    end else if (s.ai && s.bi && rsub) begin
      e.nan = 1;
    end else if (s.ai || s.bi) begin
      e.inf = 1; e.sgn = s.ai ? s.as : sbe; e.chk_sgn = 1;
    end else if ((rsub && ae == be && av == bv) || (av == 0 && bv == 0)) begin
      e.zero = 1; e.sgn = rsub ? (s.rm == 3'd3) : s.as;
      e.chk_sgn = 1; e.chk_exp = 1; e.chk_st = 1;
    end else begin
      a_l  = (ae > be) || (ae == be && av >= bv);
      lv   = (a_l ? av : bv) * 10;
      sv   = (a_l ? bv : av) * 10;
      diff = a_l ? ae - be : be - ae;
      d    = (diff > N + 1) ? N + 1 : diff;
      p    = pow10(d);
      sal  = sv / p;
      e.sticky = ((sv % p) != 0);
      r = rsub ? lv - sal : lv + sal;
      if (r < 0) r = r + pow10(N + 1);
      e.sig  = int2bcd(r);
      e.zero = (r == 0) && !e.sticky;
      e.ex   = e.zero ? 16'h0 : (a_l ? s.ae : s.be);
      e.sgn  = a_l ? s.as : sbe;
      e.chk_sgn = 1; e.chk_exp = 1; e.chk_st = 1;
      e.lat  = 2 + d + N + 1;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on each new result, then checks it is held while waiting.
  logic        prev_v = 1'b0;
  logic [23:0] h_sig;
  logic [15:0] h_exp;
  logic [4:0]  h_flags;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (o_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("o_nan", o_nan, e.nan);
          chk("o_inf", o_inf, e.inf);
          chk("o_zero", o_zero, e.zero);
          chk("o_sig", o_sig, e.sig);
          if (e.chk_sgn) chk("o_sgn", o_sgn, e.sgn);
          if (e.chk_exp) chk("o_exp", o_exp, e.ex);
          if (e.chk_st) chk("o_sticky", o_sticky, e.sticky);
          chk("latency", cyc - e.acc, e.lat);
        end
        h_sig   = o_sig;
        h_exp   = o_exp;
        h_flags = {o_sgn, o_sticky, o_inf, o_nan, o_zero};
      end else if (o_valid && prev_v) begin
        chk("hold_sig", o_sig, h_sig);
        chk("hold_exp", o_exp, h_exp);
        chk("hold_flags", {o_sgn, o_sticky, o_inf, o_nan, o_zero}, h_flags);
        chk("i_ready_in_done", i_ready, 0);
      end
      prev_v = o_valid;
    end
  end

  task automatic drive(input stim_t s);
    rm = s.rm; op = s.op; a_sgn = s.as; b_sgn = s.bs; a_exp = s.ae; b_exp = s.be;
    a_sig = s.asig; b_sig = s.bsig; a_inf = s.ai; b_inf = s.bi; a_nan = s.an; b_nan = s.bn;
  endtask

  task automatic do_op(input stim_t s, input int stall_at, input int stall_len,
                       input int rdy_dly);
    exp_t e;
    bit   got;
    e = model(s);
    e.lat = e.lat + stall_len;
    drive(s);
    got = 0;
    for (int j = 0; j < 50; j++) begin
      if (i_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    e.acc = cyc;
    sb.push_back(e);
    if (stall_len > 0) begin
      repeat (stall_at) begin @(posedge clk); #1; end
      ce = 1'b0;
      repeat (stall_len) begin @(posedge clk); #1; end
      ce = 1'b1;
    end
    got = 0;
    for (int k = 0; k < 300; k++) begin
      if (o_valid) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      chk("result_timeout", 0, 1);
      return;
    end
    repeat (rdy_dly) begin @(posedge clk); #1; end
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    chk("o_valid_after_hs", o_valid, 0);
    chk("i_ready_after_hs", i_ready, 1);
  endtask

  function automatic stim_t mk(input logic o, input logic as, input logic bs,
                               input logic [15:0] asig, input logic [15:0] ae,
                               input logic [15:0] bsig, input logic [15:0] be);
    stim_t s;
    s.rm = 3'd0; s.op = o; s.as = as; s.bs = bs; s.asig = asig; s.bsig = bsig;
    s.ae = ae; s.be = be; s.ai = 0; s.bi = 0; s.an = 0; s.bn = 0;
    return s;
  endfunction

  function automatic logic [15:0] rnd_sig();
    logic [15:0] r;
    r[15:12] = 4'($urandom_range(1, 9));
    for (int i = 0; i < 3; i++) r[i*4+:4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  stim_t dir[$];

  initial begin
    stim_t s;
    int    cls, diff;
    bit    seen;
    rst_n = 1'b0; ce = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    drive(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0));
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_i_ready", i_ready, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_sig", o_sig, 0);
    chk("rst_o_flags", {o_sgn, o_sticky, o_inf, o_nan, o_zero, o_exp}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_i_ready", i_ready, 1);

    // Directed cases
    dir.push_back(mk(0, 0, 0, 16'h1234, 16'd5, 16'h5678, 16'd5));
    dir.push_back(mk(0, 0, 0, 16'h1000, 16'd7, 16'h0005, 16'd5));
    dir.push_back(mk(1, 0, 0, 16'h1000, 16'd1, 16'h0001, 16'd0));
    dir.push_back(mk(0, 0, 0, 16'h9999, 16'd0, 16'h0001, 16'd0));
    dir.push_back(mk(1, 0, 0, 16'h4321, 16'd3, 16'h4321, 16'd3));
    s = mk(1, 0, 0, 16'h4321, 16'd3, 16'h4321, 16'd3); s.rm = 3'd3; dir.push_back(s);
    s = mk(1, 0, 0, 16'h0, 16'd0, 16'h0, 16'd0); s.ai = 1; s.bi = 1; dir.push_back(s);
    s = mk(1, 0, 1, 16'h0, 16'd0, 16'h0, 16'd0); s.ai = 1; s.bi = 1; dir.push_back(s);
    s = mk(0, 0, 0, 16'h1111, 16'd0, 16'h2222, 16'd0); s.an = 1; s.bn = 1; dir.push_back(s);
    s = mk(0, 1, 0, 16'h1234, 16'd2, 16'h3333, 16'd2); s.bn = 1; dir.push_back(s);
    dir.push_back(mk(0, 1, 1, 16'h5000, 16'd9, 16'h0000, 16'd300));
    foreach (dir[i]) do_op(dir[i], 0, 0, 0);

    // Hold result with o_ready low, then stall mid-ALIGN with ce low.
    do_op(mk(0, 0, 0, 16'h1234, 16'd5, 16'h5678, 16'd5), 0, 0, 5);
    do_op(mk(0, 0, 0, 16'h1000, 16'd7, 16'h0005, 16'd5), 2, 3, 0);

    // Random operations
    for (int t = 0; t < 60; t++) begin
      s.rm = 3'($urandom_range(0, 4)); s.op = 1'($urandom_range(0, 1));
      s.as = 1'($urandom_range(0, 1)); s.bs = 1'($urandom_range(0, 1));
      s.asig = rnd_sig(); s.bsig = rnd_sig();
      s.ai = 0; s.bi = 0; s.an = 0; s.bn = 0;
      s.ae = 16'($urandom_range(200, 400));
      diff = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 150))
                                         : int'($urandom_range(0, 5));
      s.be = ($urandom_range(0, 1) == 1) ? s.ae + 16'(diff) : s.ae - 16'(diff);
      cls = int'($urandom_range(0, 9));
      if (cls == 0) begin
        s.an = 1'($urandom_range(0, 1)); s.bn = ~s.an | 1'($urandom_range(0, 1));
      end else if (cls == 1) begin
        s.ai = 1'($urandom_range(0, 1)); s.bi = ~s.ai | 1'($urandom_range(0, 1));
      end else if (cls == 2) begin
        s.bsig = s.asig; s.be = s.ae; s.bs = s.as ^ s.op ^ 1'b1;
      end else if (cls == 3) begin
        s.asig = '0; s.bsig = '0;
      end
      do_op(s, 0, 0, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of ADD abandons the operation.
    drive(mk(0, 0, 0, 16'h1234, 16'd5, 16'h5678, 16'd5));
    chk("pre_rst_i_ready", i_ready, 1);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_sig", o_sig, 0);
    chk("midrst_o_flags", {o_sgn, o_sticky, o_inf, o_nan, o_zero, o_exp}, 0);
    chk("midrst_i_ready", i_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_i_ready", i_ready, 1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1;
    end
    chk("postrst_no_output", seen, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dfp_addsub_seq.md
Name: dfp_addsub_seq

Overview:
- Digit-serial decimal floating-point add/subtract engine with a valid/ready handshake. It is the area-reduced, parametrised successor to the fully pipelined DFP adder.
- Operands arrive already decomposed: sign, binary biased exponent, N BCD significand digits, inf/nan flags.
- Output is unnormalised, with a carry digit, a guard digit and a sticky bit. It feeds the existing normaliser and rounder stages.
- It aligns one digit per cycle and adds or subtracts one digit per cycle. Special cases and exact cancellation take an early-out path.

Parameters:
- N, 8, number of BCD significand digits per operand.
- EW, 16, exponent width in bits (unsigned binary, biased).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; when low, all state, counters and handshakes are frozen
- rm  in  3  rounding mode; sampled on accept
- op  in  1  0 = add, 1 = subtract; sampled on accept
- i_valid  in  1  operands valid
- i_ready  out  1  engine idle, will accept
- a_sgn, b_sgn  in  1 each  operand signs
- a_exp, b_exp  in  EW each  operand exponents
- a_sig, b_sig  in  N*4 each  BCD significands, most significant digit high
- a_inf, b_inf, a_nan, b_nan  in  1 each  special flags
- o_valid  out  1  result valid
- o_ready  in  1  consumer accepts result
- o_sgn  out  1  result sign
- o_exp  out  EW  result exponent
- o_sig  out  (N+2)*4  {carry digit, N digits, guard digit}
- o_sticky  out  1  OR of all digits shifted past the guard digit
- o_inf, o_nan, o_zero  out  1 each  result class

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - o_valid=0; all o_* data and flag outputs are 0.
  - i_ready is 0 while rst_n=0 and 1 from the first cycle after release.
  - Reset mid-operation abandons the operation; no partial output.
- Accept: i_valid & i_ready & ce at a rising edge. All inputs are registered; state goes to CMP.
- i_ready is 1 only in IDLE. Each transition below happens only on an edge where ce=1.
- CMP (1 cycle):
  - Effective b sign: sbe = b_sgn^op. realSub = a_sgn^sbe.
  - Larger magnitude L is chosen by exponent, then by significand; ties pick a. S is the other operand.
  - Working registers are N+1 digits with the guard digit appended as 0.
  - d = min(expL-expS, N+1).
  - Early-out straight to DONE (special-case priority, highest first):
    1. a_nan: nan, o_sig = {0, a_sig, 0}.
    2. b_nan: nan, o_sig = {0, b_sig, 0}.
    3. a_inf & b_inf & realSub: nan, o_sig = 0.
    4. Any inf: inf, sign of the inf operand (a's when both), o_sig = 0.
    5. Zero result: realSub with equal exponent and significand, or both significands zero. Gives o_zero=1, o_exp=0, o_sig=0, o_sticky=0. o_sgn = (rm==3) for realSub; for add it is the common sign.
  - Otherwise: go to ALIGN if d>0, else ADD.
- ALIGN (d cycles): each cycle S shifts right by one digit. The digit leaving the guard position ORs into sticky. A down-counter loaded with d goes to ADD when it reaches 1.
- ADD (N+1 cycles), least significant digit first:
  - Add: BCD add with carry. The final carry becomes the carry digit.
  - Subtract: L-S with ten's-complement borrow. The result is never negative; the carry digit is 0.
  - A digit counter wraps at N+1, then state goes to DONE.
- Result fields:
  - o_sgn is the sign of L (sbe when L=b).
  - o_exp = expL.
  - o_zero=1 if every digit of the result is 0 and sticky is 0; o_exp is then forced to 0.
- DONE: o_valid=1 and outputs are held stable. When o_ready&ce, go to IDLE and clear o_valid; i_ready rises the next cycle.
- Latency from accept edge to o_valid high:
  - Normal: 2+d+(N+1) cycles.
  - Early-out: 2 cycles.
- Throughput: one operation in flight. A new accept is possible no earlier than the cycle after the result handshake.
- Invalid BCD digits (values A–F) in inputs: result undefined, no hang.

Test Plan (N=4):
1. a=1234 e5, b=5678 e5, add → o_sig=0_6912_0, o_exp=5, sticky=0, o_valid 7 cycles after accept.
2. a=1000 e7, b=0005 e5, add → d=2, o_sig=0_1000_0, sticky=1, o_exp=7, latency 9.
3. a=1000 e1, b=0001 e0, sub → o_sig=0_0999_9, o_sgn=0, o_exp=1, sticky=0; and a=9999 e0 + b=0001 e0 → o_sig=1_0000_0.
4. a=4321 e3, b=4321 e3, sub, rm=0 → o_zero=1, o_sgn=0, o_exp=0, latency 2; repeat with rm=3 → o_sgn=1.
5. a=+inf, b=+inf, sub → o_nan=1; a=+inf, b=−inf, sub → o_inf=1, o_sgn=0; a_nan with b_nan → payload taken from a_sig.
6. Hold o_ready low 5 cycles in DONE → outputs stable and i_ready=0; toggle ce low mid-ALIGN → latency extends by the stall cycles. Pulse rst_n low mid-ADD → o_valid=0 and outputs 0 immediately, i_ready=1 after release.
